// File: rtl/rf_write_queue_pkg.sv
// Shared types for the register-file write queue: entry layout and the zero-register constant.
package rfq_pkg;

    localparam int RFQ_AW = 5;
    localparam int RFQ_DW = 32;

    typedef struct packed {
        logic [RFQ_AW-1:0] addr;
        logic [RFQ_DW-1:0] data;
    } entry_t;

    localparam logic [RFQ_AW-1:0] REG_ZERO = '0;

endpackage

// File: rtl/rf_write_queue_if.sv
// Producer-side request pair plus the register-file write port of rf_write_queue.
// slave = queue side, master = producers / register file side.
interface rf_write_queue_if
    import rfq_pkg::*;
#(
    parameter int AW = RFQ_AW,
    parameter int DW = RFQ_DW
);
    logic          in0_valid;
    logic [AW-1:0] in0_addr;
    logic [DW-1:0] in0_data;
    logic          in1_valid;
    logic [AW-1:0] in1_addr;
    logic [DW-1:0] in1_data;
    logic          in_ready;
    logic          RFen;
    logic [AW-1:0] A3;
    logic [DW-1:0] WD;

    modport slave (
        input  in0_valid, in0_addr, in0_data,
        input  in1_valid, in1_addr, in1_data,
        output in_ready, RFen, A3, WD
    );

    modport master (
        output in0_valid, in0_addr, in0_data,
        output in1_valid, in1_addr, in1_data,
        input  in_ready, RFen, A3, WD
    );
endinterface

// File: rtl/rf_write_queue_match.sv
// Youngest-match finder over the occupied queue entries; purely combinational.
// Walks oldest to youngest so the last hit (nearest tail) wins.
module rfq_match
    import rfq_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = PW + 1
) (
    input  entry_t              ents_i [DEPTH],
    input  logic [PW-1:0]       head_i,
    input  logic [CW-1:0]       count_i,
    input  logic [RFQ_AW-1:0]   q_addr_i,
    output logic                hit_o,
    output logic [RFQ_DW-1:0]   data_o
);

    logic [PW-1:0] idx;

    always_comb begin
        hit_o  = 1'b0;
        data_o = '0;
        idx    = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head_i + PW'(i);
            if ((CW'(i) < count_i) && (q_addr_i != REG_ZERO) &&
                (ents_i[idx].addr == q_addr_i)) begin
                hit_o  = 1'b1;
                data_o = ents_i[idx].data;
            end
        end
    end

endmodule

// File: rtl/rf_write_queue.sv
// Two-in / one-out in-order register-file write queue; optional pending-write lookup (RF_WRITE_QUEUE_BYPASS_EN).
// Latency 1 cycle enqueue-to-RFen; in_ready needs >=2 free slots, excess requests dropped and flagged in sticky ovf.
module rf_write_queue
    import rfq_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int AW    = RFQ_AW,
    localparam int DW    = RFQ_DW,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic              clk,
    input  logic              reset,
    rf_write_queue_if.slave   wq,
    input  logic              hold,
    input  logic              flush,
    output logic [CW-1:0]     count,
    output logic              empty,
    output logic              full,
    output logic              ovf
`ifdef RF_WRITE_QUEUE_BYPASS_EN
    ,
    input  logic [AW-1:0]     q_addr1,
    input  logic [AW-1:0]     q_addr2,
    output logic              q_hit1,
    output logic              q_hit2,
    output logic [DW-1:0]     q_data1,
    output logic [DW-1:0]     q_data2
`endif
);

    entry_t        mem_q [DEPTH];
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d;

    logic          in_ready;
    logic          en0, en1;
    logic          wr0, wr1;
    logic          deq;
    logic          not_empty;
    logic [PW-1:0] wr1_ptr;

    always_comb begin
        not_empty = (count_q != '0);
        // Readiness looks only at current occupancy, never at this cycle's pop.
        in_ready  = (count_q <= CW'(DEPTH - 2));
        en0       = wq.in0_valid && (wq.in0_addr != REG_ZERO);
        en1       = wq.in1_valid && (wq.in1_addr != REG_ZERO);
        wr0       = in_ready && en0 && !flush;
        wr1       = in_ready && en1 && !flush;
        deq       = not_empty && !hold && !flush && !reset;
        wr1_ptr   = tail_q + PW'(wr0);
        tail_d    = tail_q + PW'(wr0) + PW'(wr1);
        head_d    = head_q + PW'(deq);
        count_d   = count_q + CW'(wr0) + CW'(wr1) - CW'(deq);
        ovf_d     = ovf_q | (!in_ready && !flush && (en0 || en1));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else if (flush) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    // Payload storage needs no reset: it is only observed through count_q.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (wr0) mem_q[tail_q]  <= entry_t'{addr: wq.in0_addr, data: wq.in0_data};
            if (wr1) mem_q[wr1_ptr] <= entry_t'{addr: wq.in1_addr, data: wq.in1_data};
        end
    end

    always_comb begin
        wq.in_ready = in_ready;
        wq.RFen     = deq;
        wq.A3       = '0;
        wq.WD       = '0;
        if (not_empty && !reset) begin
            wq.A3 = mem_q[head_q].addr;
            wq.WD = mem_q[head_q].data;
        end
    end

    assign count = count_q;
    assign empty = !not_empty;
    assign full  = (count_q == CW'(DEPTH));
    assign ovf   = ovf_q;

`ifdef RF_WRITE_QUEUE_BYPASS_EN
    rfq_match #(.DEPTH(DEPTH)) u_match1 (
        .ents_i   (mem_q),
        .head_i   (head_q),
        .count_i  (count_q),
        .q_addr_i (q_addr1),
        .hit_o    (q_hit1),
        .data_o   (q_data1)
    );

    rfq_match #(.DEPTH(DEPTH)) u_match2 (
        .ents_i   (mem_q),
        .head_i   (head_q),
        .count_i  (count_q),
        .q_addr_i (q_addr2),
        .hit_o    (q_hit2),
        .data_o   (q_data2)
    );
`endif

endmodule

// File: doc/rf_write_queue.md
# rf_write_queue

Write-side front end for the general register file in the pipelined CPU. Accepts up to two register-write requests per cycle from result producers (port 0: W-stage writeback, port 1: multiply/divide result return), buffers them in order, and drains exactly one per cycle onto the register file's write port (RFen/A3/WD). Optionally exposes a youngest-match lookup of pending writes so the forwarding logic sees values not yet committed to the register file.

## Interface
- DEPTH, 4, queue entries; power of two, ≥ 2
- AW, 5, register address width
- DW, 32, data width

- clk  in  1  clock, all state updates on posedge
- reset  in  1  synchronous, active-high; clears queue
- in0_valid  in  1  write request, port 0 (older when both valid)
- in0_addr  in  AW  destination register, port 0
- in0_data  in  DW  write data, port 0
- in1_valid  in  1  write request, port 1
- in1_addr  in  AW  destination register, port 1
- in1_data  in  DW  write data, port 1
- in_ready  out  1  free slots ≥ 2 this cycle
- hold  in  1  freeze draining (queue may still fill)
- flush  in  1  discard all pending and same-cycle requests
- RFen  out  1  register file write enable
- A3  out  AW  register file write address
- WD  out  DW  register file write data
- count  out  clog2(DEPTH)+1  occupied entries
- empty  out  1  count == 0
- full  out  1  count == DEPTH
- ovf  out  1  sticky: request arrived while in_ready = 0
- q_addr1, q_addr2  in  AW  lookup addresses (BYPASS_EN only)
- q_hit1, q_hit2  out  1  pending write to that address exists (BYPASS_EN only)
- q_data1, q_data2  out  DW  youngest pending data for that address (BYPASS_EN only)

## Operation
- Storage: circular buffer, DEPTH entries {addr, data}; head/tail pointers wrap modulo DEPTH; count tracked separately (full/empty unambiguous).
- Enqueue: requests with addr == 0 are dropped (not stored, not ovf). When in_ready = 1, valid nonzero requests are written at tail in order port 0 then port 1; tail advances by 0, 1 or 2.
- in_ready = (DEPTH − count ≥ 2); computed from current count only, ignoring same-cycle dequeue.
- Request with valid = 1 while in_ready = 0: discarded, ovf set; ovf cleared only by reset.
- Drain: RFen = !empty && !hold && !flush; A3/WD = head entry (0 when empty). When RFen = 1 the head pops at the edge.
- Simultaneous enqueue and dequeue: count_next = count + enq − deq; legal at any occupancy.
- flush: at the edge, head = tail = 0, count = 0; same-cycle requests discarded; ovf unaffected.
- Priority: reset > flush > normal operation.
- Lookup (BYPASS_EN): hit when q_addr ≠ 0 and any occupied entry matches; data from youngest matching entry (nearest tail). Same-cycle input requests are not searched. Miss → q_data = 0.

## Timing
- Reset values: RFen 0, A3 0, WD 0, count 0, empty 1, full 0, in_ready 1, ovf 0, q_hit 0, q_data 0.
- Enqueue-to-RFen latency: 1 cycle (entry written at edge N is visible at head after edge N when queue was empty).
- RFen/A3/WD, in_ready, empty, full, q_* combinational from registered state plus hold/flush/q_addr; no input-to-output path from in*_valid.
- Reset asserted mid-drain: RFen low in the reset cycle, all pending entries lost.

## Configuration
- RF_WRITE_QUEUE_BYPASS_EN defined: q_addr*/q_hit*/q_data* ports and match logic present.
- Undefined: those ports absent; queue behaviour otherwise identical.

## Structure
- Shared package rfq_pkg: entry typedef {addr, data}, constant REG_ZERO = 0.
- One sub-module, rfq_match: combinational youngest-match finder over the entry array given head and count; instantiated once per lookup port.

## Test plan
- Reset, then in0 {addr 5, data 0x1111} -> next cycle RFen 1, A3 5, WD 0x1111; following cycle empty 1.
- Both ports same cycle {3, 0xA}, {3, 0xB} -> drains 0xA then 0xB on consecutive cycles; q_addr1 = 3 before first drain gives q_hit1 1, q_data1 0xB.
- Write to addr 0 on port 1 with port 0 addr 7 -> only one entry stored, count 1.
- hold high, enqueue 2 per cycle from empty with DEPTH 4 -> in_ready 0 after 2 cycles; third-cycle request sets ovf 1, count stays 4, full 1.
- Full queue, hold low, flush high with both requests valid -> RFen 0 that cycle, count 0 next cycle, no request retained.
- Continuous 1-per-cycle enqueue for 3×DEPTH cycles -> pointer wrap, RFen every cycle after the first, data stream in order.
